// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: word/register typedefs and
// the four pipeline-register payload structs.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        word_t instr;
        word_t npc;
    } ifid_t;

    typedef struct packed {
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        word_t    npc;
        regbits_t wsel;
        logic     wen;
        logic     dren;
        logic     dwen;
        logic     halt;
    } idex_t;

    typedef struct packed {
        word_t    alu_out;
        word_t    wdat;
        regbits_t wsel;
        logic     wen;
        logic     dren;
        logic     dwen;
        logic     halt;
    } exmem_t;

    typedef struct packed {
        word_t    alu_out;
        word_t    dload;
        regbits_t wsel;
        logic     wen;
        logic     halt;
    } memwb_t;

endpackage

// File: rtl/pipeline_latch_if.sv
// Control/data bundle between the hazard unit and the pipeline latch bank;
// mirrors hazard_unit_if with a latch-side (pl) and a hazard-side (hz) view.
interface pipeline_latch_if;
    import cpu_types_pkg::*;

    logic   ifW, idW, exW, memW;
    logic   ifRST, idRST, exRST, memRST;
    ifid_t  ifid_in,  ifid_out;
    idex_t  idex_in,  idex_out;
    exmem_t exmem_in, exmem_out;
    memwb_t memwb_in, memwb_out;
    logic   ifid_v, idex_v, exmem_v, memwb_v;
    logic   halt;

    modport pl (
        input  ifW, idW, exW, memW, ifRST, idRST, exRST, memRST,
        input  ifid_in, idex_in, exmem_in, memwb_in,
        output ifid_out, idex_out, exmem_out, memwb_out,
        output ifid_v, idex_v, exmem_v, memwb_v, halt
    );

    modport hz (
        output ifW, idW, exW, memW, ifRST, idRST, exRST, memRST,
        output ifid_in, idex_in, exmem_in, memwb_in,
        input  ifid_out, idex_out, exmem_out, memwb_out,
        input  ifid_v, idex_v, exmem_v, memwb_v, halt
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline register of arbitrary payload type with flush/write/hold
// priority, a valid bit, and a freeze input that overrides everything.
module pipe_stage_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic freeze,
    input  logic w,
    input  logic flush,
    input  logic v_in,
    input  T     d,
    output T     q,
    output logic v
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            v <= 1'b0;
        end else if (!freeze) begin
            if (flush) begin
                q <= '0;
                v <= 1'b0;
            end else if (w) begin
                q <= d;
                v <= v_in;
            end
        end
    end

endmodule

// File: rtl/pipeline_latch_bank.sv
// IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers with per-stage valid,
// sticky halt and optional stall/flush counters (PIPE_PERF_CNT_EN).
module pipeline_latch_bank
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ifW,
    input  logic             idW,
    input  logic             exW,
    input  logic             memW,
    input  logic             ifRST,
    input  logic             idRST,
    input  logic             exRST,
    input  logic             memRST,
    input  ifid_t            ifid_in,
    input  idex_t            idex_in,
    input  exmem_t           exmem_in,
    input  memwb_t           memwb_in,
    output ifid_t            ifid_out,
    output idex_t            idex_out,
    output exmem_t           exmem_out,
    output memwb_t           memwb_out,
    output logic             ifid_v,
    output logic             idex_v,
    output logic             exmem_v,
    output logic             memwb_v,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipeline_latch_if plif ();

    memwb_t memwb_raw;
    logic   halt_q;

    assign plif.ifW      = ifW;
    assign plif.idW      = idW;
    assign plif.exW      = exW;
    assign plif.memW     = memW;
    assign plif.ifRST    = ifRST;
    assign plif.idRST    = idRST;
    assign plif.exRST    = exRST;
    assign plif.memRST   = memRST;
    assign plif.ifid_in  = ifid_in;
    assign plif.idex_in  = idex_in;
    assign plif.exmem_in = exmem_in;
    assign plif.memwb_in = memwb_in;

    pipe_stage_reg #(.T(ifid_t)) u_ifid (
        .clk(CLK), .rst_n(nRST), .freeze(halt_q),
        .w(plif.ifW), .flush(plif.ifRST), .v_in(1'b1),
        .d(plif.ifid_in), .q(plif.ifid_out), .v(plif.ifid_v)
    );

    pipe_stage_reg #(.T(idex_t)) u_idex (
        .clk(CLK), .rst_n(nRST), .freeze(halt_q),
        .w(plif.idW), .flush(plif.idRST), .v_in(plif.ifid_v),
        .d(plif.idex_in), .q(plif.idex_out), .v(plif.idex_v)
    );

    pipe_stage_reg #(.T(exmem_t)) u_exmem (
        .clk(CLK), .rst_n(nRST), .freeze(halt_q),
        .w(plif.exW), .flush(plif.exRST), .v_in(plif.idex_v),
        .d(plif.exmem_in), .q(plif.exmem_out), .v(plif.exmem_v)
    );

    pipe_stage_reg #(.T(memwb_t)) u_memwb (
        .clk(CLK), .rst_n(nRST), .freeze(halt_q),
        .w(plif.memW), .flush(plif.memRST), .v_in(plif.exmem_v),
        .d(plif.memwb_in), .q(memwb_raw), .v(plif.memwb_v)
    );

    // A bubble in MEM/WB must never write the register file.
    always_comb begin
        plif.memwb_out     = memwb_raw;
        plif.memwb_out.wen = memwb_raw.wen & plif.memwb_v;
    end

    // Sticky halt: set once a valid HALT sits in MEM/WB, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_q <= 1'b0;
        end else if (plif.memwb_v && memwb_raw.halt) begin
            halt_q <= 1'b1;
        end
    end

    assign plif.halt = halt_q;

    assign ifid_out  = plif.ifid_out;
    assign idex_out  = plif.idex_out;
    assign exmem_out = plif.exmem_out;
    assign memwb_out = plif.memwb_out;
    assign ifid_v    = plif.ifid_v;
    assign idex_v    = plif.idex_v;
    assign exmem_v   = plif.exmem_v;
    assign memwb_v   = plif.memwb_v;
    assign halt      = plif.halt;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (!halt_q) begin
            if (!ifW) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (ifRST || idRST) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_latch_bank.sv
// Self-checking bench for pipeline_latch_bank: a toy decode/execute/memory
// chain feeds the stage inputs, and a scoreboard tracks MEM/WB retirements.
module tb_pipeline_latch_bank;
    import cpu_types_pkg::*;

    localparam int unsigned CNT_W = 32;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ifW, idW, exW, memW;
    logic             ifRST, idRST, exRST, memRST;
    ifid_t            ifid_in;
    idex_t            idex_in;
    exmem_t           exmem_in;
    memwb_t           memwb_in;
    ifid_t            ifid_out;
    idex_t            idex_out;
    exmem_t           exmem_out;
    memwb_t           memwb_out;
    logic             ifid_v, idex_v, exmem_v, memwb_v;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int               vec_cnt = 0;
    int               err_cnt = 0;
    memwb_t           sb_q[$];
    bit               sb_en = 1'b0;
    bit               wr_pend = 1'b0;
    bit               halted_exp = 1'b0;
    bit               use_ovr = 1'b0;
    memwb_t           memwb_ovr;
    word_t            pc;
    logic [CNT_W-1:0] s_exp, f_exp;

    pipeline_latch_bank #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .ifW(ifW), .idW(idW), .exW(exW), .memW(memW),
        .ifRST(ifRST), .idRST(idRST), .exRST(exRST), .memRST(memRST),
        .ifid_in(ifid_in), .idex_in(idex_in), .exmem_in(exmem_in), .memwb_in(memwb_in),
        .ifid_out(ifid_out), .idex_out(idex_out), .exmem_out(exmem_out), .memwb_out(memwb_out),
        .ifid_v(ifid_v), .idex_v(idex_v), .exmem_v(exmem_v), .memwb_v(memwb_v),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic idex_t dec(input ifid_t f);
        idex_t r;
        r.rdat1 = word_t'(f.instr[25:21]) + 32'h100;
        r.rdat2 = word_t'(f.instr[20:16]);
        r.imm   = {{16{f.instr[15]}}, f.instr[15:0]};
        r.npc   = f.npc;
        r.wsel  = (f.instr[31:26] == 6'h00) ? f.instr[15:11] : f.instr[20:16];
        r.wen   = 1'b1;
        r.dren  = (f.instr[31:26] == 6'h23);
        r.dwen  = (f.instr[31:26] == 6'h2B);
        r.halt  = (f.instr[31:26] == 6'h3F);
        return r;
    endfunction

    function automatic exmem_t ex(input idex_t d);
        exmem_t r;
        r.alu_out = d.rdat1 + d.imm;
        r.wdat    = d.rdat2;
        r.wsel    = d.wsel;
        r.wen     = d.wen;
        r.dren    = d.dren;
        r.dwen    = d.dwen;
        r.halt    = d.halt;
        return r;
    endfunction

    function automatic memwb_t mem(input exmem_t e);
        memwb_t r;
        r.alu_out = e.alu_out;
        r.dload   = e.dren ? (e.alu_out ^ 32'hA5A5A5A5) : 32'h0;
        r.wsel    = e.wsel;
        r.wen     = e.wen;
        r.halt    = e.halt;
        return r;
    endfunction

    // Toy datapath between the latches.
    always_comb begin
        idex_in  = dec(ifid_out);
        exmem_in = ex(idex_out);
        memwb_in = use_ovr ? memwb_ovr : mem(exmem_out);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cnts(input string tag);
`ifdef PIPE_PERF_CNT_EN
        check({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(s_exp));
        check({tag, "_flush_cnt"}, 128'(flush_cnt), 128'(f_exp));
`else
        check({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(0));
        check({tag, "_flush_cnt"}, 128'(flush_cnt), 128'(0));
`endif
    endtask

    // Scoreboard: a MEM/WB write of a valid instruction retires the oldest entry.
    always @(posedge CLK) wr_pend <= sb_en && memW && !memRST && exmem_v && !halt;

    always @(negedge CLK) begin
        if (wr_pend) begin
            check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0) check("memwb_out", 128'(memwb_out), 128'(sb_q.pop_front()));
        end
    end

    task automatic step(input logic [3:0] w, input logic [3:0] r, input word_t instr);
        {ifW, idW, exW, memW}         = w;
        {ifRST, idRST, exRST, memRST} = r;
        ifid_in.instr = instr;
        ifid_in.npc   = pc + 32'd4;
        pc            = pc + 32'd4;
        if (!halted_exp) begin
            if (!w[3]) s_exp = s_exp + CNT_W'(1);
            if (r[3] || r[2]) f_exp = f_exp + CNT_W'(1);
        end
        if (sb_en && w[3] && !r[3] && !halted_exp) sb_q.push_back(mem(ex(dec(ifid_in))));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        {ifW, idW, exW, memW}         = 4'b0;
        {ifRST, idRST, exRST, memRST} = 4'b0;
        ifid_in    = '0;
        sb_q.delete();
        sb_en      = 1'b0;
        use_ovr    = 1'b0;
        halted_exp = 1'b0;
        pc         = '0;
        s_exp      = '0;
        f_exp      = '0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        memwb_ovr = '0;
        // Reset state
        nRST = 1'b0;
        {ifW, idW, exW, memW}         = 4'b0;
        {ifRST, idRST, exRST, memRST} = 4'b0;
        ifid_in = '0;
        pc      = '0;
        s_exp   = '0;
        f_exp   = '0;
        #1;
        check("rst_ifid_out", 128'(ifid_out), 128'(0));
        check("rst_memwb_out", 128'(memwb_out), 128'(0));
        check("rst_valids", 128'({ifid_v, idex_v, exmem_v, memwb_v}), 128'(0));
        check("rst_halt", 128'(halt), 128'(0));
        check_cnts("rst");
        do_reset();

        // Asynchronous reset in the middle of a cycle
        step(4'b1000, 4'b0000, 32'h8C220004);
        check("load_instr", 128'(ifid_out.instr), 128'(32'h8C220004));
        check("load_ifid_v", 128'(ifid_v), 128'(1));
        #2 nRST = 1'b0;
        #1;
        check("async_ifid_out", 128'(ifid_out), 128'(0));
        check("async_ifid_v", 128'(ifid_v), 128'(0));
        check("async_cnts", 128'({stall_cnt, flush_cnt}), 128'(0));
        do_reset();

        // Straight flow, then drain with IF flushes
        sb_en = 1'b1;
        step(4'b1111, 4'b0000, 32'h00221820);
        step(4'b1111, 4'b0000, 32'h8C220004);
        step(4'b1111, 4'b0000, 32'h20430010);
        step(4'b1111, 4'b1000, 32'h12345678);
        check("flow_memwb_v", 128'(memwb_v), 128'(1));
        check("flow_wsel", 128'(memwb_out.wsel), 128'(3));
        check("flow_wen", 128'(memwb_out.wen), 128'(1));
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b1000, 32'hDEADBEEF);
        check("drain_memwb_v", 128'(memwb_v), 128'(0));
        check("drain_wen_gated", 128'(memwb_out.wen), 128'(0));
        check("drain_sb_empty", 128'(sb_q.size()), 128'(0));
        check_cnts("flow");

        // Stall IF/ID and ID/EX while EX/MEM and MEM/WB keep writing
        do_reset();
        step(4'b1111, 4'b0000, 32'h8C640008);
        step(4'b1111, 4'b0000, 32'h00A63820);
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0000, 32'hFFFF0000);
        check("stall_ifid_instr", 128'(ifid_out.instr), 128'(32'h00A63820));
        check("stall_ifid_v", 128'(ifid_v), 128'(1));
        check("stall_idex_v", 128'(idex_v), 128'(1));
        check("stall_idex_wsel", 128'(idex_out.wsel), 128'(4));
        check("stall_exmem_v", 128'(exmem_v), 128'(1));
        check("stall_exmem_wsel", 128'(exmem_out.wsel), 128'(4));
        check("stall_memwb_v", 128'(memwb_v), 128'(1));
        check_cnts("stall");

        // Flush beats write
        step(4'b1000, 4'b1000, 32'hCAFEF00D);
        check("flushpri_ifid_out", 128'(ifid_out), 128'(0));
        check("flushpri_ifid_v", 128'(ifid_v), 128'(0));
        check("flushpri_idex_v", 128'(idex_v), 128'(1));
        check_cnts("flushpri");

        // Invalid MEM/WB keeps its payload but never reports wen
        step(4'b0010, 4'b0010, 32'h0);
        check("exflush_exmem_v", 128'(exmem_v), 128'(0));
        memwb_ovr = '{alu_out: 32'h55, dload: 32'h0, wsel: 5'd7, wen: 1'b1, halt: 1'b0};
        use_ovr   = 1'b1;
        step(4'b0001, 4'b0000, 32'h0);
        use_ovr   = 1'b0;
        check("gate_memwb_v", 128'(memwb_v), 128'(0));
        check("gate_wsel", 128'(memwb_out.wsel), 128'(7));
        check("gate_alu", 128'(memwb_out.alu_out), 128'(32'h55));
        check("gate_wen", 128'(memwb_out.wen), 128'(0));
        check_cnts("gate");

        // Halt retires, then freezes every stage and the counters
        do_reset();
        sb_en = 1'b1;
        step(4'b1111, 4'b0000, 32'hFC000000);
        step(4'b1111, 4'b1000, 32'h0);
        step(4'b1111, 4'b1000, 32'h0);
        step(4'b1111, 4'b0000, 32'h01234567);
        check("halt_memwb_v", 128'(memwb_v), 128'(1));
        check("halt_memwb_halt", 128'(memwb_out.halt), 128'(1));
        check("halt_not_yet", 128'(halt), 128'(0));
        step(4'b0000, 4'b0000, 32'h0);
        halted_exp = 1'b1;
        check("halt_set", 128'(halt), 128'(1));
        for (int i = 0; i < 2; i++) step(4'b1111, 4'b1111, 32'h76543210);
        check("halted_ifid_instr", 128'(ifid_out.instr), 128'(32'h01234567));
        check("halted_ifid_v", 128'(ifid_v), 128'(1));
        check("halted_memwb_v", 128'(memwb_v), 128'(1));
        check("halted_sticky", 128'(halt), 128'(1));
        check_cnts("halted");

        // Only reset clears halt
        do_reset();
        check("unhalt", 128'(halt), 128'(0));
        check("unhalt_ifid_v", 128'(ifid_v), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_latch_bank.md
Name: pipeline_latch_bank

Overview:
- Receiving end of the hazard unit's control outputs.
- Holds the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined datapath and applies the per-stage write-enable (ifW..memW) and flush (ifRST..memRST) strobes each cycle.
- Tracks a valid bit per stage, latches a sticky halt once a HALT reaches MEM/WB, and optionally counts stall and flush cycles for performance reporting.

Parameters:
- WORD_W, 32, datapath word width (instr, pc, data).
- CNT_W, 32, width of the stall and flush counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ifW, idW, exW, memW  in  1 each  stage write enables, from the hazard unit.
- ifRST, idRST, exRST, memRST  in  1 each  stage flush strobes, from the hazard unit.
- ifid_in  in  ifid_t  next IF/ID contents: instr, npc.
- idex_in  in  idex_t  next ID/EX contents: rdat1, rdat2, imm, npc, control bits including halt.
- exmem_in  in  exmem_t  next EX/MEM contents: alu_out, wdat, wsel, control bits including halt.
- memwb_in  in  memwb_t  next MEM/WB contents: alu_out, dload, wsel, wen, halt.
- ifid_out, idex_out, exmem_out, memwb_out  out  struct  registered stage contents.
- ifid_v, idex_v, exmem_v, memwb_v  out  1 each  stage holds a real instruction.
- halt  out  1  sticky: the pipeline has retired a HALT.
- stall_cnt  out  CNT_W  cycles with ifW=0 while not halted.
- flush_cnt  out  CNT_W  cycles with ifRST or idRST asserted.

Behaviour:
- Reset: nRST low clears, asynchronously, every stage struct to all-zero, all valid bits, halt, and both counters.
- Per stage, on each rising CLK, with priority in this order:
  1. Flush (xRST=1): struct cleared to zero, valid=0. Flush beats write when both are asserted.
  2. Write (xW=1): struct loads its input.
  3. Otherwise: struct and valid hold.
- Valid on write:
  - ifid_v is set to 1.
  - Each downstream valid copies the upstream valid as it stood before the edge: idex_v<=ifid_v, exmem_v<=idex_v, memwb_v<=exmem_v.
  - A bubble therefore propagates as valid=0.
- Latency: exactly one cycle per stage; an instruction written into IF/ID reaches memwb_out 4 cycles later with no stalls.
- Halt:
  - halt is set on the edge after memwb_v=1 and memwb_out.halt=1.
  - Once set, all W inputs are ignored and all stages hold; xRST is also ignored.
  - Only nRST clears halt.
- wen gating: memwb_out.wen is forced to 0 whenever memwb_v=0, so a flushed stage never writes the register file.
- Independence: stages update independently. A stalled upstream stage (xW=0) alongside a writing downstream stage is legal, and the downstream stage captures its input as given.
- Counters:
  - Both increment by 1 and wrap modulo 2^CNT_W.
  - Neither increments while halt=1.
  - A cycle with both ifW=0 and a flush increments both counters.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt are implemented as specified above.
- Undefined: no counter flops are built; stall_cnt and flush_cnt are tied to 0. All other behaviour is unchanged.

Decomposition:
- cpu_types_pkg holds:
  - the stage structs ifid_t, idex_t, exmem_t, memwb_t;
  - the word_t and regbits_t typedefs;
  - WORD_W.
- The control ports are grouped in a pipeline_latch_if interface, mirroring hazard_unit_if, with two modports:
  - pl: inputs W/RST and stage inputs, outputs stage outputs, valids and halt;
  - hz-side: the complementary directions.
- One sub-module, pipe_stage_reg, is the parameterized-by-type single stage with flush, write, hold and valid logic. It is instantiated four times.

Test Plan:
- Reset mid-run: load ifid_in.instr=0x8C220004 with ifW=1, then pulse nRST=0 asynchronously mid-cycle -> all outputs 0 immediately, ifid_v=0.
- Straight flow: all W=1, instr 0x00221820 into IF/ID at cycle 0 -> after 4 edges memwb_v=1, and memwb_out carries the matching wsel=3, wen=1.
- Stall: ifW=idW=0, exW=memW=1 for 3 cycles -> ifid_out unchanged; a bubble (idex_v=0) does not appear since idW holds; stall_cnt=3 (PIPE_PERF_CNT_EN defined).
- Flush priority: ifW=1 and ifRST=1 on the same edge with nonzero ifid_in -> ifid_out=0, ifid_v=0, flush_cnt increments by 1.
- Halt: feed memwb_in.halt=1 with memW=1 -> halt=1 the following edge; a subsequent ifW=1 with new data leaves ifid_out unchanged; counters frozen.
- Feature off: compile without PIPE_PERF_CNT_EN, repeat the stall test -> stall_cnt=0, stage behaviour identical.
